inst_rom_arbiter: RTL

Shares the single combinational instruction ROM port between two requesters: port 0 is the IF stage (instruction fetch) and port 1 is a secondary reader (data-side load from code space / debug). It arbitrates with fixed priority for fetch and a starvation guard for port 1. It drives the ROM chip-enable and address, and returns each read through a registered, per-port response slot with valid/ready handshake.

---
 rtl/inst_rom_arbiter_pkg.sv | 18 +
 rtl/inst_rom_resp_slot.sv | 37 +++
 rtl/inst_rom_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/inst_rom_arbiter_pkg.sv
// rtl/inst_rom_arbiter_pkg.sv - shared constants for the instruction ROM arbiter
// Purpose: chip-enable levels, zero word, wait-counter width and default starvation limit.
package inst_rom_arbiter_pkg;

    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    localparam int          ARB_WAIT_W   = 4;
    localparam int          ARB_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_PORT0 = 2'b01,
        WIN_PORT1 = 2'b10
    } win_t;

endpackage

// File: rtl/inst_rom_resp_slot.sv
// rtl/inst_rom_resp_slot.sv - one registered response slot with valid/ready handshake
// Purpose: captures a ROM word on load and holds it until consumed.
// Ports: clk, rst (async high); flush kills the slot; load captures data_in;
//        rready consumer accept; rvalid/rdata the registered response.
module inst_rom_resp_slot
    import inst_rom_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    // Flush beats load beats consume; a load while the old word is being
    // consumed refills the slot in the same cycle (back-to-back streaming).
    // rdata is only written on load, so it keeps its last value after consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (flush) begin
            rvalid <= 1'b0;
        end else if (load) begin
            rvalid <= 1'b1;
            rdata  <= data_in;
        end else if (rready && rvalid) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_rom_arbiter.sv
// rtl/inst_rom_arbiter.sv - two-port arbiter onto a single combinational instruction ROM
// Purpose: port 0 (fetch) has fixed priority, port 1 wins after MAX_WAIT refused cycles.
// Ports: clk, rst (async high); req/addr/gnt/rdata/rvalid/rready per port;
//        flush0_i redirects port 0; rom_ce_o/rom_addr_o/rom_data_i to the ROM.
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic              flush0_i,
    output logic              gnt0_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic              rvalid0_o,
    input  logic              rready0_i,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic              gnt1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              rvalid1_o,
    input  logic              rready1_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    localparam logic [ARB_WAIT_W-1:0] WAIT_LIMIT = ARB_WAIT_W'(MAX_WAIT);

    logic [ARB_WAIT_W-1:0] wait_cnt;
    logic                  elig0;
    logic                  elig1;
    win_t                  win;

    // A slot can take a new word when empty or when being drained this cycle.
    assign elig0 = !rst && req0_i && !flush0_i && (!rvalid0_o || rready0_i);
    assign elig1 = !rst && req1_i && (!rvalid1_o || rready1_i);

    always_comb begin
        win        = WIN_NONE;
        rom_ce_o   = CHIP_DISABLE;
        rom_addr_o = '0;
        if (elig1 && (!elig0 || wait_cnt == WAIT_LIMIT)) begin
            win        = WIN_PORT1;
            rom_ce_o   = CHIP_ENABLE;
            rom_addr_o = addr1_i;
        end else if (elig0) begin
            win        = WIN_PORT0;
            rom_ce_o   = CHIP_ENABLE;
            rom_addr_o = addr0_i;
        end
    end

    assign gnt0_o = (win == WIN_PORT0);
    assign gnt1_o = (win == WIN_PORT1);

    // Counts cycles port 1 was ready to go but lost; a backpressured port 1
    // holds its count rather than clearing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!req1_i || gnt1_o) begin
            wait_cnt <= '0;
        end else if (elig1 && wait_cnt < WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    inst_rom_resp_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush0_i),
        .load    (gnt0_o),
        .data_in (rom_data_i),
        .rready  (rready0_i),
        .rvalid  (rvalid0_o),
        .rdata   (rdata0_o)
    );

    inst_rom_resp_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .flush   (1'b0),
        .load    (gnt1_o),
        .data_in (rom_data_i),
        .rready  (rready1_i),
        .rvalid  (rvalid1_o),
        .rdata   (rdata1_o)
    );

endmodule
